lsu_axi_master: RTL and testbench
=================================

// Module: lsu_axi_master
// PURPOSE
//  AXI-lite master for the LSU. Converts one core-side load/store request into one
//  AXI-lite read (AR/R) or write (AW/W/B) transaction toward the data SRAM slave.
//  Generates wstrb and lane-shifted wdata. Lane-extracts and sign/zero-extends load data.
//  One transaction outstanding at a time; misaligned accesses are rejected without any bus traffic.
// PARAMETERS
//  ADDR_W   32   address width (AXI_ADDR_BUS)
//  DATA_W   32   data width; only 32 supported (wstrb is 4 bits)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   reset, asynchronous assert, active-low
//  req_valid    in   1   core request valid
//  req_ready    out  1   request accepted when req_valid && req_ready
//  req_we       in   1   1=store, 0=load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned in bits [7:0], [15:0] or [31:0]
//  req_size     in   2   00=byte, 01=half, 10=word; 11 is treated as an error
//  req_unsigned in   1   load zero-extend (lbu/lhu) when 1, sign-extend when 0
//  resp_valid   out  1   one-cycle completion pulse; no backpressure
//  resp_rdata   out  32  extended load data; 0 for stores and for errors
//  resp_err     out  1   misaligned access, illegal size, or nonzero rresp/bresp
//  araddr/arvalid/arready, rdata/rresp/rvalid/rready             AXI-lite read channels (master side)
//  awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready   AXI-lite write channels
// BEHAVIOUR
//  Reset (rst_n low, async)
//   - state=IDLE.
//   - All AXI valids and readies are 0; resp_valid=0, resp_rdata=0, resp_err=0.
//   - Any in-flight transaction is abandoned; the slave is reset with the same rst_n.
//  req_ready
//   - Combinational, req_ready = (state==IDLE).
//   - On accept, req_* are latched; no other req_* is sampled until IDLE is re-entered.
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
//  IDLE -> RESP on accept when the access is misaligned or illegal; resp_err=1, no AXI activity.
//   - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//   - Illegal: req_size=11.
//  IDLE -> RD_ADDR on an accepted legal load.
//   - arvalid=1 from the next cycle; araddr = latched byte address.
//   - arvalid and araddr are held stable until arready.
//  RD_ADDR -> RD_DATA on arvalid&&arready.
//   - arvalid drops and rready=1.
//   - rvalid is ignored while in RD_ADDR because rready=0 there.
//  RD_DATA -> RESP on rvalid&&rready.
//   - Lane select: lane = rdata >> (8*addr[1:0]).
//   - Byte loads extend lane[7:0]; half loads extend lane[15:0]. Extension per req_unsigned.
//   - resp_err = (rresp!=2'b00); resp_rdata = 0 when resp_err=1.
//  IDLE -> WR_REQ on an accepted legal store.
//   - awvalid=1 and wvalid=1 together from the next cycle.
//   - awaddr = byte address; wdata = req_wdata << (8*addr[1:0]).
//   - wstrb = {0001|0011|1111 for b/h/w} << addr[1:0].
//   - Each valid drops the cycle after its own handshake; AW and W may complete in either order or in the same cycle.
//   - Payloads are held stable until each handshake completes.
//  WR_REQ -> WR_RESP once both aw_done and w_done are set; bready=1 in WR_RESP.
//  WR_RESP -> RESP on bvalid&&bready; resp_err = (bresp!=00); resp_rdata = 0.
//  RESP: resp_valid=1 for exactly one cycle, then IDLE.
//   - req_ready=0 during RESP.
//   - A new request is accepted no earlier than the cycle after resp_valid.
//  Latency
//   - Load: slave asserts rvalid in cycle k -> resp_valid in cycle k+1.
//   - Store: bvalid in cycle k -> resp_valid in cycle k+1.
//   - Error: accept in cycle 0 -> resp_valid in cycle 1.
//  resp_rdata/resp_err are registered; they hold their value after resp_valid until the next RESP.
// TESTING
//  - lw: addr=0x80000004, rdata=0x11223344, slave delay 0..7 (LFSR) -> resp_rdata=0x11223344, err=0.
//  - lb: addr=0x80000003, rdata=0x80FF0000 -> resp_rdata=0xFFFFFF80; same with lbu -> 0x00000080.
//  - sh: addr=0x80000002, wdata=0x0000BEEF -> wstrb=1100, wdata=0xBEEF0000, awaddr=0x80000002.
//  - Write handshakes: awready in cycle 1, wready in cycle 3 -> awvalid low from cycle 2.
//     wvalid held to cycle 3 -> bready is asserted only after both handshakes complete.
//  - Misaligned: lw addr=0x80000002 -> resp_err=1 in cycle 1; arvalid/awvalid never asserted.
//  - rst_n asserted low while in RD_DATA -> all valids 0 immediately.
//     After release, req_ready=1 and a following sw completes normally.

Source files
------------

// File: rtl/lsu_axi_master_if.sv
// LSU core request/response and AXI-lite master bundle.
// master: LSU side; slave: core + SRAM slave side.
`timescale 1ns/1ps
interface lsu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_size, req_unsigned,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    output req_valid, req_we, req_addr,
    output req_wdata, req_size, req_unsigned,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/lsu_axi_master.sv
// LSU AXI-lite master: one load/store -> one AXI-lite read or write.
// Ports: clk, rst_n (async active-low), bus (lsu_axi_master_if.master).
`timescale 1ns/1ps
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  lsu_axi_master_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RESP
  } state_e;

  state_e r_state;
  state_e w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_size;
  logic              r_uns;
  logic              r_aw_done;
  logic              r_w_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_bad;
  logic [4:0]        w_sh;
  logic [3:0]        w_strb;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_ext;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;

  always_comb begin
    w_accept = bus.req_valid && (r_state == S_IDLE);
    w_bad    = (bus.req_size == 2'b11)
            || ((bus.req_size == 2'b01) && bus.req_addr[0])
            || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    w_sh     = {bus.req_addr[1:0], 3'b000};
    w_ar_hs  = bus.arvalid && bus.arready;
    w_r_hs   = bus.rvalid  && bus.rready;
    w_aw_hs  = bus.awvalid && bus.awready;
    w_w_hs   = bus.wvalid  && bus.wready;
    w_b_hs   = bus.bvalid  && bus.bready;
  end

  always_comb begin
    w_strb = 4'b1111;
    unique case (1'b1)
      bus.req_size == 2'b00: w_strb = 4'b0001;
      bus.req_size == 2'b01: w_strb = 4'b0011;
      default:               w_strb = 4'b1111;
    endcase
  end

  // Lane-align the returned word, then extend the byte/half.
  always_comb begin
    w_lane = bus.rdata >> {r_addr[1:0], 3'b000};
    w_ext  = w_lane;
    unique case (1'b1)
      r_size == 2'b00:
        w_ext = r_uns ? {{(DATA_W-8){1'b0}}, w_lane[7:0]}
                      : {{(DATA_W-8){w_lane[7]}}, w_lane[7:0]};
      r_size == 2'b01:
        w_ext = r_uns ? {{(DATA_W-16){1'b0}}, w_lane[15:0]}
                      : {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]};
      default:
        w_ext = w_lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_bad)           w_next = S_RESP;
          else if (bus.req_we) w_next = S_WR_REQ;
          else                 w_next = S_RD_ADDR;
        end
      end
      S_RD_ADDR: if (w_ar_hs) w_next = S_RD_DATA;
      S_RD_DATA: if (w_r_hs)  w_next = S_RESP;
      S_WR_REQ: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
          w_next = S_WR_RESP;
      end
      S_WR_RESP: if (w_b_hs) w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (r_state == S_IDLE);
    bus.arvalid    = (r_state == S_RD_ADDR);
    bus.araddr     = r_addr;
    bus.rready     = (r_state == S_RD_DATA);
    bus.awvalid    = (r_state == S_WR_REQ) && !r_aw_done;
    bus.awaddr     = r_addr;
    bus.wvalid     = (r_state == S_WR_REQ) && !r_w_done;
    bus.wdata      = r_wdata;
    bus.wstrb      = r_wstrb;
    bus.bready     = (r_state == S_WR_RESP);
    bus.resp_valid = (r_state == S_RESP);
    bus.resp_rdata = r_rdata;
    bus.resp_err   = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_size    <= '0;
      r_uns     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= bus.req_addr;
        r_wdata   <= bus.req_wdata << w_sh;
        r_wstrb   <= w_strb << bus.req_addr[1:0];
        r_size    <= bus.req_size;
        r_uns     <= bus.req_unsigned;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        // Rejected access goes straight to RESP, so load the result now.
        if (w_bad) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == S_WR_REQ) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      if ((r_state == S_RD_DATA) && w_r_hs) begin
        r_err   <= (bus.rresp != 2'b00);
        r_rdata <= (bus.rresp != 2'b00) ? '0 : w_ext;
      end
      if ((r_state == S_WR_RESP) && w_b_hs) begin
        r_err   <= (bus.bresp != 2'b00);
        r_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master.
// Directed vector table plus handshake/reset sequences.
`timescale 1ns/1ps
module tb_lsu_axi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_axi_master_if #(.ADDR_W(32), .DATA_W(32)) intf ();

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (intf)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] srdata;
    logic [1:0]  sresp;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_bus;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_ar = 0, n_aw = 0, n_w = 0, n_vc = 0;
  int t_r = 0, t_b = 0;
  logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0;
  logic [3:0]  cap_wstrb = 0;
  logic f_ar = 0, f_r = 0, f_aw = 0, f_w = 0, f_b = 0;

  int d_ar = 0, d_r = 0, d_aw = 0, d_w = 0, d_b = 0;
  logic [31:0] s_rdata = 0;
  logic [1:0]  s_resp = 0;
  logic [15:0] lfsr = 16'hACE1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic int nxt_dly();
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    return int'(lfsr[2:0]);
  endfunction

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    f_ar <= intf.arvalid && intf.arready;
    f_r  <= intf.rvalid  && intf.rready;
    f_aw <= intf.awvalid && intf.awready;
    f_w  <= intf.wvalid  && intf.wready;
    f_b  <= intf.bvalid  && intf.bready;
    if (intf.arvalid && intf.arready) begin
      n_ar <= n_ar + 1;
      cap_araddr <= intf.araddr;
    end
    if (intf.awvalid && intf.awready) begin
      n_aw <= n_aw + 1;
      cap_awaddr <= intf.awaddr;
    end
    if (intf.wvalid && intf.wready) begin
      n_w <= n_w + 1;
      cap_wdata <= intf.wdata;
      cap_wstrb <= intf.wstrb;
    end
    if (intf.rvalid && intf.rready) t_r <= cyc;
    if (intf.bvalid && intf.bready) t_b <= cyc;
    if (intf.arvalid || intf.awvalid || intf.wvalid) n_vc <= n_vc + 1;
  end

  // AXI-lite slave with per-channel delays set by the test.
  initial begin
    bit ar_arm, aw_arm, w_arm, aw_got, w_got, r_pend, b_pend;
    int ar_wait, aw_wait, w_wait, r_wait, b_wait;
    {ar_arm, aw_arm, w_arm, aw_got, w_got, r_pend, b_pend} = '0;
    {ar_wait, aw_wait, w_wait, r_wait, b_wait} = '0;
    intf.arready = 0; intf.rvalid = 0; intf.rdata = 0; intf.rresp = 0;
    intf.awready = 0; intf.wready = 0; intf.bvalid = 0; intf.bresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        intf.arready = 0; intf.rvalid = 0;
        intf.awready = 0; intf.wready = 0; intf.bvalid = 0;
        {ar_arm, aw_arm, w_arm, aw_got, w_got, r_pend, b_pend} = '0;
      end else begin
        if (f_ar) begin
          intf.arready = 0; ar_arm = 0; r_pend = 1; r_wait = d_r;
        end
        if (f_r) intf.rvalid = 0;
        if (f_aw) begin intf.awready = 0; aw_arm = 0; aw_got = 1; end
        if (f_w)  begin intf.wready = 0;  w_arm = 0;  w_got = 1;  end
        if (f_b) intf.bvalid = 0;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; b_pend = 1; b_wait = d_b;
        end
        if (intf.arvalid && !intf.arready) begin
          if (!ar_arm) begin ar_arm = 1; ar_wait = d_ar; end
          if (ar_wait == 0) intf.arready = 1; else ar_wait--;
        end
        if (intf.awvalid && !intf.awready) begin
          if (!aw_arm) begin aw_arm = 1; aw_wait = d_aw; end
          if (aw_wait == 0) intf.awready = 1; else aw_wait--;
        end
        if (intf.wvalid && !intf.wready) begin
          if (!w_arm) begin w_arm = 1; w_wait = d_w; end
          if (w_wait == 0) intf.wready = 1; else w_wait--;
        end
        if (r_pend) begin
          if (r_wait == 0) begin
            intf.rvalid = 1; intf.rdata = s_rdata;
            intf.rresp = s_resp; r_pend = 0;
          end else r_wait--;
        end
        if (b_pend) begin
          if (b_wait == 0) begin
            intf.bvalid = 1; intf.bresp = s_resp; b_pend = 0;
          end else b_wait--;
        end
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [31:0] addr,
      input logic [31:0] wd, input logic [1:0] sz, input logic un,
      input logic [31:0] srd, input logic [1:0] srs,
      input logic [31:0] erd, input logic eer, input int ebus,
      input logic [3:0] estrb, input logic [31:0] ewd);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.size = sz; v.uns = un;
    v.srdata = srd; v.sresp = srs; v.exp_rdata = erd; v.exp_err = eer;
    v.exp_bus = ebus; v.exp_wstrb = estrb; v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int bus0, vc0, ar0, aw0, w0, ca;
    bit got;
    s_rdata = v.srdata;
    s_resp  = v.sresp;
    @(negedge clk);
    intf.req_valid = 1; intf.req_we = v.we; intf.req_addr = v.addr;
    intf.req_wdata = v.wdata; intf.req_size = v.size;
    intf.req_unsigned = v.uns;
    chk({tag, " req_ready"}, 32'(intf.req_ready), 32'd1);
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; vc0 = n_vc; ca = cyc;
    @(negedge clk);
    intf.req_valid = 0;
    got = 0;
    for (int c = 0; c < 80 && !got; c++) begin
      if (intf.resp_valid) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout act=no_resp exp=resp_valid", tag);
      return;
    end
    chk({tag, " rdata"}, intf.resp_rdata, v.exp_rdata);
    chk({tag, " err"}, 32'(intf.resp_err), 32'(v.exp_err));
    bus0 = (n_ar - ar0) + (n_aw - aw0) + (n_w - w0);
    if (v.exp_bus == 0) begin
      chk({tag, " lat"}, 32'(cyc), 32'(ca + 1));
      chk({tag, " no_bus"}, 32'(n_vc - vc0), 32'd0);
    end else if (v.exp_bus == 1) begin
      chk({tag, " lat"}, 32'(cyc), 32'(t_r + 1));
      chk({tag, " nbus"}, 32'(bus0), 32'd1);
      chk({tag, " araddr"}, cap_araddr, v.addr);
    end else begin
      chk({tag, " lat"}, 32'(cyc), 32'(t_b + 1));
      chk({tag, " nbus"}, 32'(bus0), 32'd2);
      chk({tag, " awaddr"}, cap_awaddr, v.addr);
      chk({tag, " wdata"}, cap_wdata, v.exp_wdata);
      chk({tag, " wstrb"}, 32'(cap_wstrb), 32'(v.exp_wstrb));
    end
    @(negedge clk);
    chk({tag, " pulse"}, 32'(intf.resp_valid), 32'd0);
    chk({tag, " rdy_after"}, 32'(intf.req_ready), 32'd1);
    chk({tag, " hold"}, intf.resp_rdata, v.exp_rdata);
  endtask

  vec_t vt[15];

  initial begin
    bit seen;
    vt[0]  = mk(0, 32'h80000004, 0, 2'b10, 0, 32'h11223344, 0,
                32'h11223344, 0, 1, 0, 0);
    vt[1]  = mk(0, 32'h80000003, 0, 2'b00, 0, 32'h80FF0000, 0,
                32'hFFFFFF80, 0, 1, 0, 0);
    vt[2]  = mk(0, 32'h80000003, 0, 2'b00, 1, 32'h80FF0000, 0,
                32'h00000080, 0, 1, 0, 0);
    vt[3]  = mk(0, 32'h80000002, 0, 2'b01, 0, 32'h80FF1234, 0,
                32'hFFFF80FF, 0, 1, 0, 0);
    vt[4]  = mk(0, 32'h80000000, 0, 2'b01, 1, 32'h12348765, 0,
                32'h00008765, 0, 1, 0, 0);
    vt[5]  = mk(0, 32'h80000001, 0, 2'b00, 0, 32'h00007F00, 0,
                32'h0000007F, 0, 1, 0, 0);
    vt[6]  = mk(1, 32'h80000002, 32'h0000BEEF, 2'b01, 0, 0, 0,
                0, 0, 2, 4'b1100, 32'hBEEF0000);
    vt[7]  = mk(1, 32'h80000001, 32'h000000AB, 2'b00, 0, 0, 0,
                0, 0, 2, 4'b0010, 32'h0000AB00);
    vt[8]  = mk(1, 32'h80000008, 32'hDEADBEEF, 2'b10, 0, 0, 0,
                0, 0, 2, 4'b1111, 32'hDEADBEEF);
    vt[9]  = mk(0, 32'h80000002, 0, 2'b10, 0, 0, 0,
                0, 1, 0, 0, 0);
    vt[10] = mk(1, 32'h80000003, 32'h1234, 2'b01, 0, 0, 0,
                0, 1, 0, 0, 0);
    vt[11] = mk(0, 32'h80000000, 0, 2'b11, 0, 0, 0,
                0, 1, 0, 0, 0);
    vt[12] = mk(0, 32'h80000000, 0, 2'b10, 0, 32'hCAFEF00D, 2'b10,
                0, 1, 1, 0, 0);
    vt[13] = mk(1, 32'h80000000, 32'h55667788, 2'b10, 0, 0, 2'b10,
                0, 1, 2, 4'b1111, 32'h55667788);
    vt[14] = mk(0, 32'h80000007, 0, 2'b00, 1, 32'hA5000000, 0,
                32'h000000A5, 0, 1, 0, 0);

    intf.req_valid = 0; intf.req_we = 0; intf.req_addr = 0;
    intf.req_wdata = 0; intf.req_size = 0; intf.req_unsigned = 0;
    repeat (3) @(negedge clk);
    chk("rst arvalid", 32'(intf.arvalid), 0);
    chk("rst awvalid", 32'(intf.awvalid), 0);
    chk("rst resp_valid", 32'(intf.resp_valid), 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst req_ready", 32'(intf.req_ready), 1);
    chk("rst resp_rdata", intf.resp_rdata, 0);
    chk("rst resp_err", 32'(intf.resp_err), 0);

    for (int i = 0; i < 15; i++) begin
      d_ar = nxt_dly(); d_r = nxt_dly(); d_aw = nxt_dly();
      d_w = nxt_dly(); d_b = nxt_dly();
      run_vec(vt[i], $sformatf("v%0d", i));
    end

    // Write handshake ordering: AW in cycle 1, W in cycle 3.
    d_aw = 0; d_w = 2; d_b = 0; s_resp = 0;
    @(negedge clk);
    intf.req_valid = 1; intf.req_we = 1; intf.req_addr = 32'h80000010;
    intf.req_wdata = 32'h12345678; intf.req_size = 2'b10;
    @(negedge clk);
    intf.req_valid = 0;
    chk("wh c1 awvalid", 32'(intf.awvalid), 1);
    chk("wh c1 wvalid", 32'(intf.wvalid), 1);
    chk("wh c1 bready", 32'(intf.bready), 0);
    @(negedge clk);
    chk("wh c2 awvalid", 32'(intf.awvalid), 0);
    chk("wh c2 wvalid", 32'(intf.wvalid), 1);
    chk("wh c2 bready", 32'(intf.bready), 0);
    @(negedge clk);
    chk("wh c3 wvalid", 32'(intf.wvalid), 1);
    chk("wh c3 wdata", intf.wdata, 32'h12345678);
    chk("wh c3 bready", 32'(intf.bready), 0);
    @(negedge clk);
    chk("wh c4 wvalid", 32'(intf.wvalid), 0);
    chk("wh c4 bready", 32'(intf.bready), 1);
    @(negedge clk);
    chk("wh c5 resp_valid", 32'(intf.resp_valid), 1);
    chk("wh c5 err", 32'(intf.resp_err), 0);
    @(negedge clk);

    // Reset while waiting in RD_DATA.
    d_ar = 0; d_r = 7; s_rdata = 32'h99999999; s_resp = 0;
    @(negedge clk);
    intf.req_valid = 1; intf.req_we = 0; intf.req_addr = 32'h80000020;
    intf.req_size = 2'b10;
    @(negedge clk);
    intf.req_valid = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (intf.rready) seen = 1;
      else @(negedge clk);
    end
    chk("rr reached rd_data", 32'(seen), 1);
    #2 rst_n = 0;
    #1;
    chk("rr rready", 32'(intf.rready), 0);
    chk("rr arvalid", 32'(intf.arvalid), 0);
    chk("rr awvalid", 32'(intf.awvalid), 0);
    chk("rr wvalid", 32'(intf.wvalid), 0);
    chk("rr resp_valid", 32'(intf.resp_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rr req_ready", 32'(intf.req_ready), 1);
    d_aw = 1; d_w = 0; d_b = 2;
    run_vec(mk(1, 32'h80000024, 32'hA1B2C3D4, 2'b10, 0, 0, 0,
               0, 0, 2, 4'b1111, 32'hA1B2C3D4), "post_rst sw");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
